// File: rtl/sysx_transfer_sequencer.sv
// sysX master transfer sequencer: streams MOSI buffer words out MSB-first over
// the byte-wide bus and assembles the returned bytes into MISO buffer words.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for start; device interrupt may raise oInterrupt
//   LOAD      | present word index to the MOSI buffer
//   WAIT_DATA | buffer read latency; capture word into TX shift register
//   BYTE3..0  | shift out one byte, bus clock low half then high half
//   STORE     | write assembled RX word to the MISO buffer, bump index
//   DONE      | one-cycle completion pulse, select released
module sysx_transfer_sequencer #(
    parameter int DIV_WIDTH  = 12,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iStart,
    input  logic                  iAbort,
    input  logic [ADDR_WIDTH-1:0] iWordCount,
    input  logic [1:0]            iSelect,
    input  logic [DIV_WIDTH-1:0]  iClockDivide,
    input  logic                  iIntAck,
    output logic [ADDR_WIDTH-1:0] oMOSIAddr,
    input  logic [31:0]           iMOSIData,
    output logic [ADDR_WIDTH-1:0] oMISOAddr,
    output logic [31:0]           oMISOData,
    output logic                  oMISOWrite,
    output logic [7:0]            oBusMOSI,
    input  logic [7:0]            iBusMISO,
    output logic                  oBusClock,
    output logic [1:0]            oBusSelect,
    input  logic                  iBusInterrupt,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [ADDR_WIDTH-1:0] oWordsDone,
    output logic                  oInterrupt
);

    typedef enum logic [3:0] {
        IDLE, LOAD, WAIT_DATA, BYTE3, BYTE2, BYTE1, BYTE0, STORE, DONE
    } state_t;

    state_t                state;
    state_t                stateNext;
    logic [ADDR_WIDTH-1:0] countReg;
    logic [1:0]            selReg;
    logic [DIV_WIDTH-1:0]  divReg;
    logic [DIV_WIDTH-1:0]  divCount;
    logic                  busPhase;
    logic [ADDR_WIDTH-1:0] wordIdx;
    logic [ADDR_WIDTH-1:0] wordsDone;
    logic [31:0]           txReg;
    logic [31:0]           rxReg;
    logic                  interrupt;

    logic                  isByte;
    logic                  tick;
    logic                  startOk;
    logic [ADDR_WIDTH-1:0] idxNext;

    assign isByte  = (state == BYTE3) || (state == BYTE2) ||
                     (state == BYTE1) || (state == BYTE0);
    assign tick    = isByte && (divCount == divReg);
    assign startOk = iStart && !iAbort;
    assign idxNext = wordIdx + 1'b1;

    // State register
    always_ff @(posedge iClock) begin
        if (iReset) state <= IDLE;
        else        state <= stateNext;
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        stateNext  = state;
        oMOSIAddr  = '0;
        oMISOAddr  = '0;
        oMISOData  = '0;
        oMISOWrite = 1'b0;
        oBusMOSI   = '0;
        oBusSelect = '0;
        oBusy      = (state != IDLE);
        oDone      = 1'b0;
        case (state)
            IDLE: begin
                if (startOk) stateNext = (iWordCount == '0) ? DONE : LOAD;
            end
            LOAD: begin
                oMOSIAddr  = wordIdx;
                oBusSelect = selReg;
                stateNext  = WAIT_DATA;
            end
            WAIT_DATA: begin
                oBusSelect = selReg;
                stateNext  = BYTE3;
            end
            BYTE3: begin
                oBusMOSI   = txReg[31:24];
                oBusSelect = selReg;
                if (tick && busPhase) stateNext = BYTE2;
            end
            BYTE2: begin
                oBusMOSI   = txReg[23:16];
                oBusSelect = selReg;
                if (tick && busPhase) stateNext = BYTE1;
            end
            BYTE1: begin
                oBusMOSI   = txReg[15:8];
                oBusSelect = selReg;
                if (tick && busPhase) stateNext = BYTE0;
            end
            BYTE0: begin
                oBusMOSI   = txReg[7:0];
                oBusSelect = selReg;
                if (tick && busPhase) stateNext = STORE;
            end
            STORE: begin
                oMISOWrite = 1'b1;
                oMISOAddr  = wordIdx;
                oMISOData  = rxReg;
                oBusSelect = selReg;
                stateNext  = (idxNext == countReg) ? DONE : LOAD;
            end
            DONE: begin
                oDone     = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if ((state != IDLE) && iAbort) stateNext = IDLE;
    end

    assign oBusClock  = busPhase;
    assign oWordsDone = wordsDone;
    assign oInterrupt = interrupt;

    // Transfer datapath: latched config, divider, shift registers, counters, interrupt
    always_ff @(posedge iClock) begin
        if (iReset) begin
            countReg  <= '0;
            selReg    <= '0;
            divReg    <= '0;
            divCount  <= '0;
            busPhase  <= 1'b0;
            wordIdx   <= '0;
            wordsDone <= '0;
            txReg     <= '0;
            rxReg     <= '0;
            interrupt <= 1'b0;
        end else begin
            if ((state == IDLE) && startOk) begin
                countReg  <= iWordCount;
                selReg    <= iSelect;
                divReg    <= iClockDivide;
                wordsDone <= '0;
                wordIdx   <= '0;
            end

            if (state == WAIT_DATA) txReg <= iMOSIData;

            // Divider and bus clock phase only run inside byte states; abort
            // drops the bus clock low together with the return to IDLE.
            if (isByte && !iAbort) begin
                divCount <= tick ? '0 : divCount + 1'b1;
                if (tick) begin
                    busPhase <= ~busPhase;
                    if (!busPhase) begin
                        case (state)
                            BYTE3:   rxReg[31:24] <= iBusMISO;
                            BYTE2:   rxReg[23:16] <= iBusMISO;
                            BYTE1:   rxReg[15:8]  <= iBusMISO;
                            default: rxReg[7:0]   <= iBusMISO;
                        endcase
                    end
                end
            end else begin
                divCount <= '0;
                busPhase <= 1'b0;
            end

            if (state == STORE) begin
                wordsDone <= wordsDone + 1'b1;
                wordIdx   <= idxNext;
            end

            if ((state == DONE) || ((state == IDLE) && iBusInterrupt))
                interrupt <= 1'b1;
            else if (iIntAck)
                interrupt <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sysx_transfer_sequencer.sv
// Directed bench for sysx_transfer_sequencer with buffer RAM and bus models.
module tb_sysx_transfer_sequencer;

    localparam int DW = 12;
    localparam int AW = 8;

    logic          iClock = 1'b0;
    logic          iReset;
    logic          iStart;
    logic          iAbort;
    logic [AW-1:0] iWordCount;
    logic [1:0]    iSelect;
    logic [DW-1:0] iClockDivide;
    logic          iIntAck;
    logic [AW-1:0] oMOSIAddr;
    logic [31:0]   iMOSIData;
    logic [AW-1:0] oMISOAddr;
    logic [31:0]   oMISOData;
    logic          oMISOWrite;
    logic [7:0]    oBusMOSI;
    logic [7:0]    iBusMISO;
    logic          oBusClock;
    logic [1:0]    oBusSelect;
    logic          iBusInterrupt;
    logic          oBusy;
    logic          oDone;
    logic [AW-1:0] oWordsDone;
    logic          oInterrupt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mosiMem [4];
    logic [7:0]  respBytes [16];
    int          riseCnt  = 0;
    int          riseBase = 0;
    int          writeCnt = 0;
    int          doneCnt  = 0;
    int          wcBase;
    int          dcBase;

    sysx_transfer_sequencer #(.DIV_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .iClock(iClock), .iReset(iReset), .iStart(iStart), .iAbort(iAbort),
        .iWordCount(iWordCount), .iSelect(iSelect), .iClockDivide(iClockDivide),
        .iIntAck(iIntAck), .oMOSIAddr(oMOSIAddr), .iMOSIData(iMOSIData),
        .oMISOAddr(oMISOAddr), .oMISOData(oMISOData), .oMISOWrite(oMISOWrite),
        .oBusMOSI(oBusMOSI), .iBusMISO(iBusMISO), .oBusClock(oBusClock),
        .oBusSelect(oBusSelect), .iBusInterrupt(iBusInterrupt), .oBusy(oBusy),
        .oDone(oDone), .oWordsDone(oWordsDone), .oInterrupt(oInterrupt)
    );

    always #5 iClock = ~iClock;

    // MOSI buffer RAM with 1-cycle read latency
    always @(posedge iClock) iMOSIData <= mosiMem[oMOSIAddr[1:0]];

    // Device returns the next table byte on each rising bus clock
    always @(posedge oBusClock) riseCnt <= riseCnt + 1;
    assign iBusMISO = respBytes[4'(riseCnt - riseBase)];

    // Count MISO writes and done pulses
    always @(posedge iClock) begin
        if (oMISOWrite) writeCnt <= writeCnt + 1;
        if (oDone)      doneCnt  <= doneCnt + 1;
    end

    task automatic tickN(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iClock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic startXfer(input logic [AW-1:0] n, input logic [DW-1:0] d, input logic [1:0] sel);
        riseBase     = riseCnt;
        wcBase       = writeCnt;
        dcBase       = doneCnt;
        iWordCount   = n;
        iClockDivide = d;
        iSelect      = sel;
        iStart       = 1'b1;
        tickN(1);
        iStart       = 1'b0;
    endtask

    initial begin
        iReset = 1'b1; iStart = 1'b0; iAbort = 1'b0; iWordCount = '0;
        iSelect = '0; iClockDivide = '0; iIntAck = 1'b0; iBusInterrupt = 1'b0;
        for (int i = 0; i < 4; i++)  mosiMem[i] = '0;
        for (int i = 0; i < 16; i++) respBytes[i] = '0;
        tickN(3);
        check("rst_busy", oBusy, 0);
        check("rst_sel", oBusSelect, 0);
        check("rst_clk", oBusClock, 0);
        check("rst_wr", oMISOWrite, 0);
        check("rst_words", oWordsDone, 0);
        check("rst_int", oInterrupt, 0);
        check("rst_done", oDone, 0);
        iReset = 1'b0;
        tickN(1);

        // D=0, N=1
        mosiMem[0] = 32'h11223344;
        respBytes[0] = 8'hAA; respBytes[1] = 8'hBB; respBytes[2] = 8'hCC; respBytes[3] = 8'hDD;
        startXfer(1, 0, 2'b01);                       // C1
        check("t1_busy_c1", oBusy, 1);
        check("t1_sel_c1", oBusSelect, 2'b01);
        check("t1_mosiaddr_c1", oMOSIAddr, 0);
        tickN(2);                                     // C3
        check("t1_byte3", oBusMOSI, 8'h11);
        check("t1_clk_c3", oBusClock, 0);
        tickN(1);                                     // C4
        check("t1_clk_c4", oBusClock, 1);
        tickN(1);                                     // C5
        check("t1_byte2", oBusMOSI, 8'h22);
        tickN(2);                                     // C7
        check("t1_byte1", oBusMOSI, 8'h33);
        tickN(2);                                     // C9
        check("t1_byte0", oBusMOSI, 8'h44);
        tickN(2);                                     // C11
        check("t1_wr_c11", oMISOWrite, 1);
        check("t1_waddr", oMISOAddr, 0);
        check("t1_wdata", oMISOData, 32'hAABBCCDD);
        tickN(1);                                     // C12
        check("t1_done_c12", oDone, 1);
        check("t1_sel_c12", oBusSelect, 0);
        tickN(1);                                     // C13
        check("t1_busy_c13", oBusy, 0);
        check("t1_words", oWordsDone, 1);
        check("t1_int", oInterrupt, 1);
        iIntAck = 1'b1; tickN(1); iIntAck = 1'b0;
        check("t1_int_ack", oInterrupt, 0);

        // D=2, N=3
        mosiMem[0] = 32'hA1B2C3D4; mosiMem[1] = 32'h01020304; mosiMem[2] = 32'h05060708;
        for (int i = 0; i < 16; i++) respBytes[i] = 8'(8'h10 + i);
        startXfer(3, 2, 2'b10);                       // C1
        check("t2_sel_c1", oBusSelect, 2'b10);
        tickN(2);                                     // C3
        check("t2_byte3", oBusMOSI, 8'hA1);
        tickN(2);                                     // C5
        check("t2_clk_c5", oBusClock, 0);
        tickN(1);                                     // C6
        check("t2_clk_c6", oBusClock, 1);
        tickN(2);                                     // C8
        check("t2_clk_c8", oBusClock, 1);
        tickN(1);                                     // C9
        check("t2_clk_c9", oBusClock, 0);
        check("t2_byte2", oBusMOSI, 8'hB2);
        tickN(18);                                    // C27
        check("t2_wr_c27", oMISOWrite, 1);
        check("t2_waddr0", oMISOAddr, 0);
        check("t2_wdata0", oMISOData, 32'h10111213);
        tickN(27);                                    // C54
        check("t2_wr_c54", oMISOWrite, 1);
        check("t2_waddr1", oMISOAddr, 1);
        check("t2_wdata1", oMISOData, 32'h14151617);
        tickN(27);                                    // C81
        check("t2_wr_c81", oMISOWrite, 1);
        check("t2_waddr2", oMISOAddr, 2);
        check("t2_wdata2", oMISOData, 32'h18191A1B);
        check("t2_sel_c81", oBusSelect, 2'b10);
        tickN(1);                                     // C82
        check("t2_done_c82", oDone, 1);
        check("t2_sel_c82", oBusSelect, 0);
        tickN(1);                                     // C83
        check("t2_busy_c83", oBusy, 0);
        check("t2_words", oWordsDone, 3);
        check("t2_wrcount", writeCnt - wcBase, 3);
        iIntAck = 1'b1; tickN(1); iIntAck = 1'b0;

        // N=0
        startXfer(0, 0, 2'b11);                       // C1
        check("t3_done_c1", oDone, 1);
        check("t3_sel", oBusSelect, 0);
        check("t3_words", oWordsDone, 0);
        check("t3_clk", oBusClock, 0);
        tickN(1);                                     // C2
        check("t3_busy_c2", oBusy, 0);
        check("t3_wrcount", writeCnt - wcBase, 0);
        iIntAck = 1'b1; tickN(1); iIntAck = 1'b0;
        check("t3_int_ack", oInterrupt, 0);

        // D=0, N=3, abort in BYTE1 of word 1 (bus clock high half)
        for (int i = 0; i < 16; i++) respBytes[i] = 8'(8'h20 + i);
        startXfer(3, 0, 2'b11);                       // C1
        tickN(18);                                    // C19
        check("t4_clk_c19", oBusClock, 1);
        check("t4_byte1", oBusMOSI, 8'h03);
        iAbort = 1'b1; tickN(1); iAbort = 1'b0;       // C20
        check("t4_busy", oBusy, 0);
        check("t4_clk", oBusClock, 0);
        check("t4_sel", oBusSelect, 0);
        check("t4_words", oWordsDone, 1);
        check("t4_done", oDone, 0);
        tickN(3);
        check("t4_wrcount", writeCnt - wcBase, 1);
        check("t4_donecount", doneCnt - dcBase, 0);
        check("t4_int", oInterrupt, 0);
        mosiMem[0] = 32'hCAFEF00D;
        for (int i = 0; i < 16; i++) respBytes[i] = 8'(8'h40 + i);
        startXfer(1, 0, 2'b01);                       // C1
        tickN(2);                                     // C3
        check("t4r_byte3", oBusMOSI, 8'hCA);
        tickN(8);                                     // C11
        check("t4r_wr", oMISOWrite, 1);
        check("t4r_wdata", oMISOData, 32'h40414243);
        tickN(1);                                     // C12
        check("t4r_done", oDone, 1);
        tickN(1);
        check("t4r_words", oWordsDone, 1);
        iIntAck = 1'b1; tickN(1); iIntAck = 1'b0;

        // Start while busy ignored; reset mid-byte
        startXfer(2, 1, 2'b01);                       // C1
        tickN(2);                                     // C3
        iWordCount = 1; iStart = 1'b1; tickN(1); iStart = 1'b0;   // C4
        tickN(16);                                    // C20
        check("t5_busy_c20", oBusy, 1);
        check("t5_mosiaddr", oMOSIAddr, 1);
        check("t5_words_c20", oWordsDone, 1);
        tickN(4);                                     // C24
        check("t5_clk_c24", oBusClock, 1);
        iReset = 1'b1; tickN(1); iReset = 1'b0;       // C25
        check("t5_rst_busy", oBusy, 0);
        check("t5_rst_clk", oBusClock, 0);
        check("t5_rst_sel", oBusSelect, 0);
        check("t5_rst_words", oWordsDone, 0);
        check("t5_rst_mosi", oBusMOSI, 0);
        iStart = 1'b1; iAbort = 1'b1; tickN(1); iStart = 1'b0; iAbort = 1'b0;
        check("t5_startabort", oBusy, 0);
        tickN(1);
        check("t5_startabort2", oBusy, 0);

        // Interrupt set/clear priority
        startXfer(0, 0, 2'b00);                       // C1 (DONE)
        iIntAck = 1'b1; tickN(1);
        check("t6_setwins", oInterrupt, 1);
        tickN(1); iIntAck = 1'b0;
        check("t6_ack", oInterrupt, 0);
        iBusInterrupt = 1'b1; tickN(1); iBusInterrupt = 1'b0;
        check("t6_devint", oInterrupt, 1);
        tickN(1);
        check("t6_latched", oInterrupt, 1);
        iIntAck = 1'b1; tickN(1); iIntAck = 1'b0;
        check("t6_ack2", oInterrupt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sysx_transfer_sequencer.md
Name: sysx_transfer_sequencer

Overview:
- Single-clock sequencer for the sysX master datapath. Moves a block of 32-bit words from the MOSI buffer out over the byte-wide sysX bus, most significant byte first.
- Assembles the returned MISO bytes into words and writes them into the MISO buffer.
- Generates the divided bus clock and drives the device select.
- Raises a latched interrupt on completion or on a device interrupt.
- Sits between the CPU-facing register file and the two buffer RAMs, each of which has 1-cycle read latency.

Parameters:
DIV_WIDTH, 12, width of the bus clock divide value
ADDR_WIDTH, 8, buffer address width and word-count width

Ports:
iClock  in  1  system clock
iReset  in  1  synchronous, active-high reset
iStart  in  1  start pulse; sampled only in IDLE
iAbort  in  1  abort request
iWordCount  in  ADDR_WIDTH  number of words to transfer; 0 means no transfer
iSelect  in  2  device select code for this transfer
iClockDivide  in  DIV_WIDTH  divide value D; each bus half-period is D+1 cycles
iIntAck  in  1  clears oInterrupt
oMOSIAddr  out  ADDR_WIDTH  MOSI buffer read address
iMOSIData  in  32  MOSI buffer read data, valid 1 cycle after the address
oMISOAddr  out  ADDR_WIDTH  MISO buffer write address
oMISOData  out  32  MISO buffer write data
oMISOWrite  out  1  MISO buffer write strobe
oBusMOSI  out  8  outgoing bus byte
iBusMISO  in  8  incoming bus byte
oBusClock  out  1  bus clock
oBusSelect  out  2  device select; 0 means none
iBusInterrupt  in  1  device interrupt
oBusy  out  1  high in any state except IDLE
oDone  out  1  one-cycle completion pulse
oWordsDone  out  ADDR_WIDTH  count of words written to the MISO buffer
oInterrupt  out  1  latched interrupt

Behaviour:
- Reset values: all outputs 0; state IDLE; divider counter 0; word index 0.
- Start: iStart in IDLE latches iWordCount, iSelect and iClockDivide, then clears oWordsDone and the word index. iStart outside IDLE is ignored. If iAbort and iStart are both high in IDLE, the start is ignored.
- Zero count: iWordCount=0 goes IDLE→DONE. No select is asserted and no buffer access occurs.
- LOAD (1 cycle): oMOSIAddr = word index. oBusSelect = latched select from LOAD through STORE of the last word.
- WAIT (1 cycle): latch iMOSIData into the TX shift register.
- BYTE3, BYTE2, BYTE1, BYTE0 transmit bits 31:24, 23:16, 15:8, 7:0 in that order. Each byte state:
  - oBusMOSI = current byte for the whole state.
  - The divider counts 0..D, producing a tick when count == D, then wraps to 0. The counter is held at 0 outside byte states.
  - First half: oBusClock=0. On the tick, oBusClock→1 and iBusMISO is captured into the RX byte lane.
  - Second half: oBusClock=1. On the tick, oBusClock→0 and the state advances.
  - Each byte lasts 2(D+1) cycles.
- STORE (1 cycle):
  - oMISOWrite=1, oMISOAddr = word index, oMISOData = assembled word (first received byte in bits 31:24).
  - oWordsDone increments and the word index increments.
  - If the new index equals the count, go to DONE; otherwise go to LOAD.
- DONE (1 cycle): oDone=1, oBusSelect=0, then return to IDLE.
- Cycle count: the cycle that samples iStart is C0. A transfer of N words spans C1..C(N·(3+8(D+1))), and oDone is high in the following cycle.
- Abort: iAbort in any busy state moves to IDLE on the next edge.
  - oBusClock=0 and oBusSelect=0 immediately on entering IDLE.
  - No MISO write for the partial word and no oDone.
  - oWordsDone holds its value.
- oInterrupt:
  - Set by oDone, or by iBusInterrupt=1 while in IDLE.
  - Cleared by iIntAck; if set and clear coincide, set wins.
- Reset mid-transfer: all outputs and state return to reset values at the next edge.
- Word index arithmetic is ADDR_WIDTH-bit. The maximum count is 2^ADDR_WIDTH−1, so the index never wraps.

Test Plan:
1. D=0, N=1, MOSI[0]=0x11223344, iBusMISO returns AA,BB,CC,DD on successive rising bus clocks -> oBusMOSI sequence 11,22,33,44; MISO[0]=0xAABBCCDD written at C11; oDone at C12; oWordsDone=1; oBusy low at C13.
2. D=2, N=3 -> oBusClock period 6 cycles; MISO writes to addresses 0,1,2 at C27, C54, C81; oDone at C82; oBusSelect = iSelect from C1 to C81.
3. N=0 -> oDone at C1; oBusSelect, oBusClock and oMISOWrite stay 0; oWordsDone=0.
4. D=0, N=3, iAbort during BYTE1 of word 1 -> no write to address 1; oWordsDone=1; IDLE next cycle with oBusClock=0; no oDone. A subsequent start works normally.
5. iStart pulsed while busy, and iStart with iAbort in IDLE -> both ignored. iReset asserted mid-byte -> all outputs 0 at the next edge.
6. oDone with iIntAck in the same cycle -> oInterrupt=1; iIntAck later -> 0. iBusInterrupt=1 in IDLE -> oInterrupt=1.
